// File: rtl/sd_block_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : sd_block_read_sequencer
// Purpose : Turns a cmd_detect pulse into a run of SD block-read requests,
//           one per block, and reports done/error. Optional watchdog:
//           SEQ_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module sd_block_read_sequencer #(
  parameter int          ADDR_W      = 32,
  parameter int          CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_detect,
  input  logic [ADDR_W-1:0] start_block,
  input  logic [CNT_W-1:0]  num_blocks,
  input  logic              rd_ready,
  input  logic              rd_done,
  input  logic              rd_error,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  blocks_done
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ISSUE = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_DONE  = 3'd3;
  localparam logic [2:0] c_ERR   = 3'd4;

  localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_limit;
  logic [CNT_W-1:0]  r_blocks_done;
  logic              r_error;
  logic [CNT_W-1:0]  w_blocks_next;
  logic              w_timeout;
  logic              w_fail;

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] r_wd;

  // Cleared while issuing so the count starts at zero on entry to WAIT.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_wd <= 32'd0;
    end else if (r_state == c_ISSUE) begin
      r_wd <= 32'd0;
    end else if (r_state == c_WAIT) begin
      r_wd <= r_wd + 32'd1;
    end
  end

  assign w_timeout = (r_state == c_WAIT) && (r_wd == (TIMEOUT_CYC - 32'd1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
  assign w_timeout          = 1'b0;
`endif

  assign w_blocks_next = r_blocks_done + c_CNT_ONE;
  assign w_fail        = rd_error | w_timeout;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state       <= c_IDLE;
      r_addr        <= '0;
      r_limit       <= '0;
      r_blocks_done <= '0;
      r_error       <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (cmd_detect) begin
            r_addr        <= start_block;
            r_limit       <= num_blocks;
            r_blocks_done <= '0;
            r_error       <= 1'b0;
            r_state       <= (num_blocks == '0) ? c_DONE : c_ISSUE;
          end
        end
        c_ISSUE: begin
          if (rd_ready) begin
            r_state <= c_WAIT;
          end
        end
        c_WAIT: begin
          // A failure in the same cycle as completion does not count the block.
          if (w_fail) begin
            r_error <= 1'b1;
            r_state <= c_ERR;
          end else if (rd_done) begin
            r_blocks_done <= w_blocks_next;
            r_addr        <= r_addr + c_ADDR_ONE;
            r_state       <= (w_blocks_next == r_limit) ? c_DONE : c_ISSUE;
          end
        end
        c_DONE:  r_state <= c_IDLE;
        c_ERR:   r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign rd_req      = (r_state == c_ISSUE);
  assign rd_addr     = r_addr;
  assign busy        = (r_state != c_IDLE);
  assign done        = (r_state == c_DONE);
  assign error       = r_error;
  assign blocks_done = r_blocks_done;

endmodule
`default_nettype wire

// File: tb/tb_sd_block_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sd_block_read_sequencer
// Purpose : Directed self-checking bench for sd_block_read_sequencer.
// Revision: 1.0
// ============================================================================
module tb_sd_block_read_sequencer;

  logic        clk;
  logic        n_rst;
  logic        cmd_detect;
  logic [31:0] start_block;
  logic [15:0] num_blocks;
  logic        rd_ready;
  logic        rd_done;
  logic        rd_error;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] blocks_done;

  int n_cmp  = 0;
  int n_fail = 0;

  sd_block_read_sequencer #(
    .ADDR_W     (32),
    .CNT_W      (16),
    .TIMEOUT_CYC(10)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .cmd_detect (cmd_detect),
    .start_block(start_block),
    .num_blocks (num_blocks),
    .rd_ready   (rd_ready),
    .rd_done    (rd_done),
    .rd_error   (rd_error),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .blocks_done(blocks_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // Tasks enter and leave at a falling edge; inputs change there, outputs are sampled there.
  task automatic start_cmd(input logic [31:0] addr, input logic [15:0] num);
    cmd_detect  = 1'b1;
    start_block = addr;
    num_blocks  = num;
    @(negedge clk);
    cmd_detect = 1'b0;
  endtask

  // Expects ISSUE with rd_ready high; completes the block 5 cycles after accept.
  task automatic run_block(input logic [31:0] exp_addr, input logic err);
    n_cmp++; if (rd_req !== 1'b1) begin n_fail++; $display("FAIL blk_req: got %b expected 1", rd_req); end
    n_cmp++; if (rd_addr !== exp_addr) begin n_fail++; $display("FAIL blk_addr: got %h expected %h", rd_addr, exp_addr); end
    @(negedge clk);
    n_cmp++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL blk_req_drop: got %b expected 0", rd_req); end
    repeat (4) @(negedge clk);
    rd_done  = 1'b1;
    rd_error = err;
    @(negedge clk);
    rd_done  = 1'b0;
    rd_error = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; cmd_detect = 1'b0; start_block = '0; num_blocks = '0;
    rd_ready = 1'b0; rd_done = 1'b0; rd_error = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", rd_req); end
    n_cmp++; if (rd_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", rd_addr); end
    n_cmp++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b expected 000", {busy, done, error}); end
    n_cmp++; if (blocks_done !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", blocks_done); end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_seq();
    rd_ready = 1'b1;
    start_cmd(32'h100, 16'd3);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
    run_block(32'h100, 1'b0);
    run_block(32'h101, 1'b0);
    run_block(32'h102, 1'b0);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", done); end
    n_cmp++; if (blocks_done !== 16'd3) begin n_fail++; $display("FAIL basic_cnt: got %0d expected 3", blocks_done); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", error); end
    @(negedge clk);
    n_cmp++; if ({busy, done, rd_req} !== 3'b000) begin n_fail++; $display("FAIL basic_end: got %b expected 000", {busy, done, rd_req}); end
  endtask

  task automatic test_zero_blocks();
    start_cmd(32'h55, 16'd0);
    n_cmp++; if ({busy, done, rd_req} !== 3'b110) begin n_fail++; $display("FAIL zero_first: got %b expected 110", {busy, done, rd_req}); end
    @(negedge clk);
    n_cmp++; if ({busy, done, rd_req} !== 3'b000) begin n_fail++; $display("FAIL zero_second: got %b expected 000", {busy, done, rd_req}); end
    n_cmp++; if (blocks_done !== 16'd0) begin n_fail++; $display("FAIL zero_cnt: got %0d expected 0", blocks_done); end
  endtask

  task automatic test_ready_stall();
    rd_ready = 1'b0;
    start_cmd(32'h200, 16'd1);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({rd_req, rd_addr} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL stall_hold[%0d]: got %b/%h expected 1/00000200", i, rd_req, rd_addr); end
      if (i == 4) rd_ready = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL stall_dup[%0d]: got %b expected 0", i, rd_req); end
      @(negedge clk);
    end
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    n_cmp++; if ({done, blocks_done} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL stall_done: got %b/%0d expected 1/1", done, blocks_done); end
    @(negedge clk);
  endtask

  task automatic test_error();
    rd_ready = 1'b1;
    start_cmd(32'h300, 16'd4);
    run_block(32'h300, 1'b0);
    run_block(32'h301, 1'b1);
    n_cmp++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL err_state: got %b expected 10", {busy, done}); end
    @(negedge clk);
    n_cmp++; if ({busy, done, error} !== 3'b001) begin n_fail++; $display("FAIL err_flags: got %b expected 001", {busy, done, error}); end
    n_cmp++; if (blocks_done !== 16'd1) begin n_fail++; $display("FAIL err_cnt: got %0d expected 1", blocks_done); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({rd_req, error} !== 2'b01) begin n_fail++; $display("FAIL err_sticky: got %b expected 01", {rd_req, error}); end
    start_cmd(32'h500, 16'd1);
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", error); end
    n_cmp++; if (blocks_done !== 16'd0) begin n_fail++; $display("FAIL err_cnt_clear: got %0d expected 0", blocks_done); end
    run_block(32'h500, 1'b0);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL err_recover: got %b expected 1", done); end
    @(negedge clk);
  endtask

  task automatic test_ignore_cmd();
    rd_ready = 1'b0;
    start_cmd(32'h400, 16'd2);
    @(negedge clk);
    start_cmd(32'h999, 16'd7);
    n_cmp++; if ({rd_req, rd_addr} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL ign_issue: got %b/%h expected 1/00000400", rd_req, rd_addr); end
    rd_ready = 1'b1;
    run_block(32'h400, 1'b0);
    run_block(32'h401, 1'b0);
    n_cmp++; if ({done, blocks_done} !== {1'b1, 16'd2}) begin n_fail++; $display("FAIL ign_done: got %b/%0d expected 1/2", done, blocks_done); end
    start_cmd(32'h777, 16'd5);
    n_cmp++; if ({busy, rd_req} !== 2'b00) begin n_fail++; $display("FAIL ign_in_done: got %b expected 00", {busy, rd_req}); end
  endtask

  task automatic test_wrap();
    rd_ready = 1'b1;
    start_cmd(32'hFFFF_FFFF, 16'd2);
    run_block(32'hFFFF_FFFF, 1'b0);
    run_block(32'h0000_0000, 1'b0);
    n_cmp++; if ({done, blocks_done, error} !== {1'b1, 16'd2, 1'b0}) begin n_fail++; $display("FAIL wrap_done: got %b/%0d/%b expected 1/2/0", done, blocks_done, error); end
    @(negedge clk);
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    rd_ready = 1'b1;
    start_cmd(32'h600, 16'd1);
    @(negedge clk);
    repeat (9) @(negedge clk);
    n_cmp++; if ({busy, error} !== 2'b10) begin n_fail++; $display("FAIL to_waiting: got %b expected 10", {busy, error}); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, done, error} !== 3'b001) begin n_fail++; $display("FAIL to_err: got %b expected 001", {busy, done, error}); end
    n_cmp++; if (blocks_done !== 16'd0) begin n_fail++; $display("FAIL to_cnt: got %0d expected 0", blocks_done); end
  endtask
`endif

  task automatic test_reset_mid();
    rd_ready = 1'b1;
    start_cmd(32'h700, 16'd2);
    run_block(32'h700, 1'b0);
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({rd_req, busy, done, error} !== 4'b0000) begin n_fail++; $display("FAIL mid_flags: got %b expected 0000", {rd_req, busy, done, error}); end
    n_cmp++; if ({rd_addr, blocks_done} !== {32'h0, 16'd0}) begin n_fail++; $display("FAIL mid_regs: got %h/%0d expected 0/0", rd_addr, blocks_done); end
    n_rst = 1'b1;
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, rd_req, blocks_done} !== {1'b0, 1'b0, 16'd0}) begin n_fail++; $display("FAIL mid_idle: got %b/%b/%0d expected 0/0/0", busy, rd_req, blocks_done); end
  endtask

  initial begin
    test_reset();
    test_basic_seq();
    test_zero_blocks();
    test_ready_stall();
    test_error();
    test_ignore_cmd();
    test_wrap();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
